// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the RAM backing store.
//   rd_state_t        - read FSM states (RD_IDLE, RD_WAIT)
//   ram_wbuf_entry_t  - {addr, data} write-buffer entry at the default widths
//   ram_addr_bits()   - word-address width for a given array size
//   wbuf_ptr_bits()   - pointer width for a power-of-two write buffer
package ram_pkg;

  localparam int RAM_DATA_WIDTH_DEF     = 16;
  localparam int RAM_REGISTER_COUNT_DEF = 1024;

  function automatic int ram_addr_bits(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int wbuf_ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int RAM_ADDR_BITS_DEF = ram_addr_bits(RAM_REGISTER_COUNT_DEF);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [RAM_ADDR_BITS_DEF-1:0]  addr;
    logic [RAM_DATA_WIDTH_DEF-1:0] data;
  } ram_wbuf_entry_t;

endpackage

// File: rtl/ram_wbuf.sv
// ram_wbuf: posted-write FIFO in front of the RAM array.
//   i_push / i_push_addr / i_push_data : enqueue request (ignored while full)
//   i_lookup_addr                      : address for the forwarding lookup
//   o_full                             : count == WBUF_DEPTH
//   o_retire / o_retire_addr/_data     : head entry commits to the array this cycle
//   o_hit / o_hit_data                 : youngest valid entry matching i_lookup_addr
// The head entry occupies the array for WRITE_CYCLES cycles (drain timer),
// retires on the last one, and the next entry starts timing the cycle after.
module ram_wbuf
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_BITS    = 10,
  parameter int WBUF_DEPTH   = 4,
  parameter int WRITE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  i_push,
  input  logic [ADDR_BITS-1:0]  i_push_addr,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic [ADDR_BITS-1:0]  i_lookup_addr,
  output logic                  o_full,
  output logic                  o_retire,
  output logic [ADDR_BITS-1:0]  o_retire_addr,
  output logic [DATA_WIDTH-1:0] o_retire_data,
  output logic                  o_hit,
  output logic [DATA_WIDTH-1:0] o_hit_data
);

  localparam int PTR_BITS = wbuf_ptr_bits(WBUF_DEPTH);
  localparam int TMR_BITS = $clog2(WRITE_CYCLES + 1);
  localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(WRITE_CYCLES - 1);
  localparam logic [PTR_BITS:0]   DEPTH_CNT = (PTR_BITS + 1)'(WBUF_DEPTH);

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t              r_mem [WBUF_DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic [TMR_BITS-1:0] r_timer;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);
  // Full blocks the push even when the head retires in the same cycle.
  assign w_push  = i_push && !w_full;
  assign w_pop   = !w_empty && (r_timer == TMR_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_timer  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Timer restarts at 0 for each new head; it idles at 0 while empty.
      if (w_empty || w_pop) r_timer <= '0;
      else                  r_timer <= r_timer + 1'b1;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: i_push_addr, data: i_push_data};
  end

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (((PTR_BITS + 1)'(i) < r_count) &&
          (r_mem[r_rd_ptr + PTR_BITS'(i)].addr == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[r_rd_ptr + PTR_BITS'(i)].data;
      end
    end
  end

  assign o_full        = w_full;
  assign o_retire      = w_pop;
  assign o_retire_addr = r_mem[r_rd_ptr].addr;
  assign o_retire_data = r_mem[r_rd_ptr].data;

endmodule

// File: rtl/ram_backing_store.sv
// ram_backing_store: RAM-side responder for the CPU data cache.
//   ram_out_m / ram_write_m : write data / request (posted into ram_wbuf)
//   ram_read_m              : read request
//   ram_data_addr           : shared word address for reads and writes
//   ram_in_m                : read data, valid with ram_ready, held afterwards
//   ram_ready               : one-cycle pulse, read data valid
//   ram_busy                : a read is in flight (new reads ignored)
//   ram_wbuf_full           : write buffer full (writes not accepted)
//   o_dbg_rd_state          : read FSM state, for observation only
//
// Handshake: a write is taken in any cycle with ram_write_m && !ram_wbuf_full;
// otherwise the requester keeps ram_write_m, address and data stable. A read is
// taken when ram_read_m is high while idle or in the cycle ram_ready pulses;
// reads presented while busy otherwise are dropped, not queued. Read data is
// the value of the address as of the accept edge, including a write accepted
// in that same cycle.
module ram_backing_store
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH         = RAM_DATA_WIDTH_DEF,
  parameter  int RAM_REGISTER_COUNT = RAM_REGISTER_COUNT_DEF,
  parameter  int READ_LATENCY       = 2,
  parameter  int WRITE_CYCLES       = 3,
  parameter  int WBUF_DEPTH         = 4,
  localparam int ADDR_BITS          = ram_addr_bits(RAM_REGISTER_COUNT)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] ram_out_m,
  input  logic                  ram_write_m,
  input  logic                  ram_read_m,
  input  logic [ADDR_BITS-1:0]  ram_data_addr,
  output logic [DATA_WIDTH-1:0] ram_in_m,
  output logic                  ram_ready,
  output logic                  ram_busy,
  output logic                  ram_wbuf_full,
  output rd_state_t             o_dbg_rd_state
);

  localparam int LAT_BITS = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_BITS-1:0] LAT_LOAD = LAT_BITS'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] r_mem [RAM_REGISTER_COUNT];

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [LAT_BITS-1:0]   r_lat_cnt;
  logic [LAT_BITS-1:0]   w_lat_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] w_snapshot;

  logic                  w_full;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_done;
  logic                  w_retire;
  logic [ADDR_BITS-1:0]  w_retire_addr;
  logic [DATA_WIDTH-1:0] w_retire_data;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_hit_data;

  ram_wbuf #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_BITS   (ADDR_BITS),
    .WBUF_DEPTH  (WBUF_DEPTH),
    .WRITE_CYCLES(WRITE_CYCLES)
  ) u_wbuf (
    .clk          (clk),
    .resetN       (resetN),
    .i_push       (ram_write_m),
    .i_push_addr  (ram_data_addr),
    .i_push_data  (ram_out_m),
    .i_lookup_addr(ram_data_addr),
    .o_full       (w_full),
    .o_retire     (w_retire),
    .o_retire_addr(w_retire_addr),
    .o_retire_data(w_retire_data),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  assign w_wr_accept = ram_write_m && !w_full;
  assign w_done      = (r_state == RD_WAIT) && (r_lat_cnt == '0);
  assign w_rd_accept = ram_read_m && ((r_state == RD_IDLE) || w_done);

  // Reads and writes share one address, so a same-cycle accepted write always
  // targets the address being read and takes priority. A retiring entry is
  // still in the buffer this cycle, so the lookup covers it without a bypass.
  always_comb begin
    if (w_wr_accept)  w_snapshot = ram_out_m;
    else if (w_hit)   w_snapshot = w_hit_data;
    else              w_snapshot = r_mem[ram_data_addr];
  end

  always_ff @(posedge clk) begin
    if (w_retire) r_mem[w_retire_addr] <= w_retire_data;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    case (r_state)
      RD_IDLE: begin
        if (ram_read_m) begin
          w_state_nxt   = RD_WAIT;
          w_lat_cnt_nxt = LAT_LOAD;
        end
      end
      RD_WAIT: begin
        if (r_lat_cnt == '0) begin
          // Completion cycle doubles as an accept slot for the next read.
          if (ram_read_m) begin
            w_state_nxt   = RD_WAIT;
            w_lat_cnt_nxt = LAT_LOAD;
          end else begin
            w_state_nxt   = RD_IDLE;
          end
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt   = RD_IDLE;
        w_lat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= RD_IDLE;
      r_lat_cnt <= '0;
      r_result  <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      if (w_done)      r_hold   <= r_result;
      if (w_rd_accept) r_result <= w_snapshot;
    end
  end

  // r_result can be overwritten by a read accepted in the completion cycle,
  // so the held value lives in r_hold and ram_in_m muxes between them.
  assign ram_in_m       = w_done ? r_result : r_hold;
  assign ram_ready      = w_done;
  assign ram_busy       = (r_state == RD_WAIT);
  assign ram_wbuf_full  = w_full;
  assign o_dbg_rd_state = r_state;

endmodule
